// File: rtl/vend_controller.sv
// Vending selection/credit controller: price table, credit accumulation,
// vend pulse and greedy change payout over a valid/ready hopper handshake.
module vend_controller #(
    parameter int N_ITEMS   = 9,
    parameter int IDX_W     = 4,
    parameter int MONEY_W   = 10,
    parameter int MAX_MONEY = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               price_wr,
    input  logic [IDX_W-1:0]   price_idx,
    input  logic [MONEY_W-1:0] price_data,
    input  logic               coin_valid,
    input  logic [2:0]         coin_type,
    output logic               coin_rej,
    input  logic               sel_valid,
    input  logic [IDX_W-1:0]   sel_idx,
    output logic               sel_nak,
    input  logic               cancel,
    output logic               vend_valid,
    output logic [IDX_W-1:0]   vend_idx,
    output logic               chg_valid,
    output logic [2:0]         chg_type,
    input  logic               chg_ready,
    output logic [N_ITEMS-1:0] g_led,
    output logic [N_ITEMS-1:0] r_led,
    output logic [MONEY_W-1:0] disp_cents,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    localparam logic [IDX_W:0]     N_ITEMS_L = (IDX_W+1)'(N_ITEMS);
    localparam logic [MONEY_W:0]   MAX_L     = (MONEY_W+1)'(MAX_MONEY);
    localparam logic [MONEY_W-1:0] FIVE      = MONEY_W'(5);

    // Handshake: a change coin transfers on every rising clk edge where
    // chg_valid && chg_ready; chg_type holds while chg_valid && !chg_ready.

    function automatic logic [MONEY_W-1:0] coin_value(input logic [2:0] code);
        case (code)
            3'd0:    coin_value = MONEY_W'(5);
            3'd1:    coin_value = MONEY_W'(10);
            3'd2:    coin_value = MONEY_W'(25);
            3'd3:    coin_value = MONEY_W'(50);
            3'd4:    coin_value = MONEY_W'(100);
            3'd5:    coin_value = MONEY_W'(500);
            default: coin_value = '0;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic [MONEY_W-1:0] remain_q, remain_d;
    logic [MONEY_W-1:0] disp_q, disp_d;
    logic [IDX_W-1:0]   vend_idx_q, vend_idx_d;
    logic               coin_rej_q, coin_rej_d;
    logic               sel_nak_q, sel_nak_d;
    logic [MONEY_W-1:0] price_q [N_ITEMS];

    logic               price_we;
    logic               sel_in_range;
    logic [MONEY_W-1:0] sel_price;
    logic               sel_ok;
    logic               coin_code_ok;
    logic [MONEY_W-1:0] coin_val;
    logic [MONEY_W:0]   coin_sum;
    logic [2:0]         chg_code;
    logic [MONEY_W-1:0] chg_amt;

    assign price_we = price_wr && (state_q == S_IDLE)
                   && ({1'b0, price_idx} < N_ITEMS_L)
                   && ((price_data % FIVE) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) price_q[i] <= '0;
        end else if (price_we) begin
            price_q[price_idx] <= price_data;
        end
    end

    always_comb begin
        sel_in_range = ({1'b0, sel_idx} < N_ITEMS_L);
        sel_price    = '0;
        if (sel_in_range) sel_price = price_q[sel_idx];
        sel_ok       = sel_in_range && (sel_price != '0) && (credit_q >= sel_price);
    end

    assign coin_code_ok = (coin_type <= 3'd5);
    assign coin_val     = coin_value(coin_type);
    assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_val};

    // Greedy payout; remaining is always a multiple of 5, so code 0 finishes it.
    always_comb begin
        chg_code = 3'd0;
        if (remain_q >= MONEY_W'(100))     chg_code = 3'd4;
        else if (remain_q >= MONEY_W'(25)) chg_code = 3'd2;
        else if (remain_q >= MONEY_W'(10)) chg_code = 3'd1;
        chg_amt = coin_value(chg_code);
    end

    always_comb begin
        logic coin_blocked;
        state_d      = state_q;
        credit_d     = credit_q;
        remain_d     = remain_q;
        disp_d       = disp_q;
        vend_idx_d   = vend_idx_q;
        coin_rej_d   = 1'b0;
        sel_nak_d    = 1'b0;
        coin_blocked = 1'b1;

        case (state_q)
            S_IDLE: begin
                coin_blocked = 1'b0;
                if (sel_valid) disp_d = sel_price;
            end
            S_CREDIT: begin
                if (cancel) begin
                    state_d  = S_CHANGE;
                    remain_d = credit_q;
                    credit_d = '0;
                end else if (sel_valid) begin
                    if (sel_ok) begin
                        state_d    = S_VEND;
                        credit_d   = credit_q - sel_price;
                        vend_idx_d = sel_idx;
                    end else begin
                        sel_nak_d    = 1'b1;
                        coin_blocked = 1'b0;
                    end
                end else begin
                    coin_blocked = 1'b0;
                end
            end
            S_VEND: begin
                if (credit_q != '0) begin
                    state_d  = S_CHANGE;
                    remain_d = credit_q;
                    credit_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHANGE: begin
                if (chg_ready) begin
                    remain_d = remain_q - chg_amt;
                    if (remain_d == '0) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Coins lose to an accepted cancel/selection and to VEND/CHANGE.
        if (coin_valid) begin
            if (!coin_blocked && coin_code_ok && (coin_sum <= MAX_L)) begin
                credit_d = coin_sum[MONEY_W-1:0];
                if (state_q == S_IDLE) state_d = S_CREDIT;
            end else begin
                coin_rej_d = 1'b1;
            end
        end

        if ((state_d == S_IDLE) && (state_q != S_IDLE)) disp_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            remain_q   <= '0;
            disp_q     <= '0;
            vend_idx_q <= '0;
            coin_rej_q <= 1'b0;
            sel_nak_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            remain_q   <= remain_d;
            disp_q     <= disp_d;
            vend_idx_q <= vend_idx_d;
            coin_rej_q <= coin_rej_d;
            sel_nak_q  <= sel_nak_d;
        end
    end

    always_comb begin
        g_led = '0;
        r_led = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            r_led[i] = (price_q[i] == '0);
            g_led[i] = (price_q[i] != '0) && (credit_q >= price_q[i]);
        end
    end

    always_comb begin
        disp_cents = disp_q;
        case (state_q)
            S_CREDIT: disp_cents = credit_q;
            S_CHANGE: disp_cents = remain_q;
            S_VEND:   disp_cents = '0;
            default:  disp_cents = disp_q;
        endcase
    end

    assign coin_rej   = coin_rej_q;
    assign sel_nak    = sel_nak_q;
    assign vend_valid = (state_q == S_VEND);
    assign vend_idx   = vend_idx_q;
    assign chg_valid  = (state_q == S_CHANGE);
    assign chg_type   = chg_code;
    assign busy       = (state_q == S_VEND) || (state_q == S_CHANGE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scenario bench for vend_controller: vend/change coins are queued as
// expectations when stimulus is driven and popped as the DUT produces them.
module tb_vend_controller;

    localparam int N_ITEMS = 9;
    localparam int IDX_W   = 4;
    localparam int MONEY_W = 10;

    logic               clk;
    logic               rst_n;
    logic               price_wr;
    logic [IDX_W-1:0]   price_idx;
    logic [MONEY_W-1:0] price_data;
    logic               coin_valid;
    logic [2:0]         coin_type;
    logic               coin_rej;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_nak;
    logic               cancel;
    logic               vend_valid;
    logic [IDX_W-1:0]   vend_idx;
    logic               chg_valid;
    logic [2:0]         chg_type;
    logic               chg_ready;
    logic [N_ITEMS-1:0] g_led;
    logic [N_ITEMS-1:0] r_led;
    logic [MONEY_W-1:0] disp_cents;
    logic               busy;
    logic [1:0]         state_dbg;

    int total = 0;
    int bad   = 0;
    logic [2:0]       exp_chg_q[$];
    logic [IDX_W-1:0] exp_vend_q[$];

    vend_controller #(.N_ITEMS(N_ITEMS), .IDX_W(IDX_W), .MONEY_W(MONEY_W), .MAX_MONEY(1000)) dut (
        .clk(clk), .rst_n(rst_n),
        .price_wr(price_wr), .price_idx(price_idx), .price_data(price_data),
        .coin_valid(coin_valid), .coin_type(coin_type), .coin_rej(coin_rej),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_nak(sel_nak),
        .cancel(cancel),
        .vend_valid(vend_valid), .vend_idx(vend_idx),
        .chg_valid(chg_valid), .chg_type(chg_type), .chg_ready(chg_ready),
        .g_led(g_led), .r_led(r_led), .disp_cents(disp_cents),
        .busy(busy), .state_dbg(state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: called at a negedge, return at the next negedge.
    task automatic pulse_coin(input logic [2:0] code);
        coin_valid = 1'b1; coin_type = code;
        @(negedge clk);
        coin_valid = 1'b0;
    endtask

    task automatic pulse_sel(input logic [IDX_W-1:0] idx);
        sel_valid = 1'b1; sel_idx = idx;
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic write_price(input logic [IDX_W-1:0] idx, input logic [MONEY_W-1:0] data);
        price_wr = 1'b1; price_idx = idx; price_data = data;
        @(negedge clk);
        price_wr = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state_dbg); end
        total++; if (r_led !== 9'h1FF) begin bad++; $display("FAIL rst_r_led got=%h want=1ff", r_led); end
        total++; if (g_led !== 9'h000) begin bad++; $display("FAIL rst_g_led got=%h want=000", g_led); end
        total++; if (disp_cents !== 10'd0) begin bad++; $display("FAIL rst_disp got=%0d want=0", disp_cents); end
        total++; if ({vend_valid, chg_valid, coin_rej, sel_nak, busy} !== 5'b0)
            begin bad++; $display("FAIL rst_pulses got=%b want=00000", {vend_valid, chg_valid, coin_rej, sel_nak, busy}); end
        total++; if (vend_idx !== 4'd0) begin bad++; $display("FAIL rst_vend_idx got=%0d want=0", vend_idx); end
    endtask

    task automatic test_price_write();
        write_price(4'd0, 10'd125);
        total++; if (r_led[0] !== 1'b0) begin bad++; $display("FAIL pw_slot0_visible got=%b want=0", r_led[0]); end
        write_price(4'd1, 10'd0);
        write_price(4'd2, 10'd123);
        total++; if (r_led !== 9'h1FE) begin bad++; $display("FAIL pw_r_led got=%h want=1fe", r_led); end
        total++; if (g_led !== 9'h000) begin bad++; $display("FAIL pw_g_led got=%h want=000", g_led); end
    endtask

    task automatic test_vend_exact();
        logic [IDX_W-1:0] ev;
        pulse_coin(3'd4);
        total++; if (g_led[0] !== 1'b0 || disp_cents !== 10'd100 || state_dbg !== 2'd1)
            begin bad++; $display("FAIL ve_after_100 got g=%b disp=%0d st=%0d want g=0 disp=100 st=1", g_led[0], disp_cents, state_dbg); end
        pulse_coin(3'd2);
        total++; if (g_led[0] !== 1'b1 || disp_cents !== 10'd125)
            begin bad++; $display("FAIL ve_after_25 got g=%b disp=%0d want g=1 disp=125", g_led[0], disp_cents); end
        exp_vend_q.push_back(4'd0);
        pulse_sel(4'd0);
        ev = exp_vend_q.pop_front();
        total++; if (vend_valid !== 1'b1 || vend_idx !== ev || busy !== 1'b1 || disp_cents !== 10'd0)
            begin bad++; $display("FAIL ve_vend got v=%b idx=%0d busy=%b disp=%0d want v=1 idx=%0d busy=1 disp=0", vend_valid, vend_idx, busy, disp_cents, ev); end
        @(negedge clk);
        total++; if (state_dbg !== 2'd0 || vend_valid !== 1'b0 || chg_valid !== 1'b0 || busy !== 1'b0 || disp_cents !== 10'd0)
            begin bad++; $display("FAIL ve_idle got st=%0d v=%b cv=%b busy=%b disp=%0d want st=0 v=0 cv=0 busy=0 disp=0", state_dbg, vend_valid, chg_valid, busy, disp_cents); end
    endtask

    task automatic test_vend_change();
        logic [IDX_W-1:0] ev;
        logic [2:0] e;
        chg_ready = 1'b1;
        pulse_coin(3'd5);
        exp_vend_q.push_back(4'd0);
        for (int k = 0; k < 3; k++) exp_chg_q.push_back(3'd4);
        for (int k = 0; k < 3; k++) exp_chg_q.push_back(3'd2);
        pulse_sel(4'd0);
        ev = exp_vend_q.pop_front();
        total++; if (vend_valid !== 1'b1 || vend_idx !== ev)
            begin bad++; $display("FAIL vc_vend got v=%b idx=%0d want v=1 idx=%0d", vend_valid, vend_idx, ev); end
        @(negedge clk);
        total++; if (disp_cents !== 10'd375 || state_dbg !== 2'd3)
            begin bad++; $display("FAIL vc_change_start got disp=%0d st=%0d want disp=375 st=3", disp_cents, state_dbg); end
        for (int i = 0; i < 20 && exp_chg_q.size() != 0; i++) begin
            if (chg_valid && chg_ready) begin
                e = exp_chg_q.pop_front();
                total++; if (chg_type !== e) begin bad++; $display("FAIL vc_coin got=%0d want=%0d", chg_type, e); end
            end
            @(negedge clk);
        end
        total++; if (exp_chg_q.size() != 0) begin bad++; $display("FAIL vc_timeout got left=%0d want left=0", exp_chg_q.size()); exp_chg_q.delete(); end
        total++; if (chg_valid !== 1'b0 || state_dbg !== 2'd0)
            begin bad++; $display("FAIL vc_end got cv=%b st=%0d want cv=0 st=0", chg_valid, state_dbg); end
        chg_ready = 1'b0;
    endtask

    task automatic test_reject_nak();
        logic [2:0] e;
        pulse_coin(3'd5);
        for (int k = 0; k < 4; k++) pulse_coin(3'd4);
        total++; if (disp_cents !== 10'd900) begin bad++; $display("FAIL rn_credit got=%0d want=900", disp_cents); end
        pulse_coin(3'd5);
        total++; if (coin_rej !== 1'b1 || disp_cents !== 10'd900)
            begin bad++; $display("FAIL rn_over got rej=%b disp=%0d want rej=1 disp=900", coin_rej, disp_cents); end
        @(negedge clk);
        total++; if (coin_rej !== 1'b0) begin bad++; $display("FAIL rn_rej_pulse got=%b want=0", coin_rej); end
        pulse_coin(3'd6);
        total++; if (coin_rej !== 1'b1 || disp_cents !== 10'd900)
            begin bad++; $display("FAIL rn_badcode got rej=%b disp=%0d want rej=1 disp=900", coin_rej, disp_cents); end
        write_price(4'd1, 10'd50);
        total++; if (r_led[1] !== 1'b1) begin bad++; $display("FAIL rn_pw_credit got=%b want=1", r_led[1]); end
        pulse_sel(4'd1);
        total++; if (sel_nak !== 1'b1 || vend_valid !== 1'b0 || state_dbg !== 2'd1 || disp_cents !== 10'd900)
            begin bad++; $display("FAIL rn_oos got nak=%b v=%b st=%0d disp=%0d want nak=1 v=0 st=1 disp=900", sel_nak, vend_valid, state_dbg, disp_cents); end
        pulse_sel(4'd12);
        total++; if (sel_nak !== 1'b1 || state_dbg !== 2'd1)
            begin bad++; $display("FAIL rn_range got nak=%b st=%0d want nak=1 st=1", sel_nak, state_dbg); end
        pulse_coin(3'd4);
        total++; if (coin_rej !== 1'b0 || disp_cents !== 10'd1000 || g_led[0] !== 1'b1)
            begin bad++; $display("FAIL rn_max got rej=%b disp=%0d g=%b want rej=0 disp=1000 g=1", coin_rej, disp_cents, g_led[0]); end
        chg_ready = 1'b1;
        for (int k = 0; k < 10; k++) exp_chg_q.push_back(3'd4);
        pulse_cancel();
        total++; if (disp_cents !== 10'd1000 || chg_valid !== 1'b1)
            begin bad++; $display("FAIL rn_cancel got disp=%0d cv=%b want disp=1000 cv=1", disp_cents, chg_valid); end
        for (int i = 0; i < 30 && exp_chg_q.size() != 0; i++) begin
            if (chg_valid && chg_ready) begin
                e = exp_chg_q.pop_front();
                total++; if (chg_type !== e) begin bad++; $display("FAIL rn_coin got=%0d want=%0d", chg_type, e); end
            end
            @(negedge clk);
        end
        total++; if (exp_chg_q.size() != 0) begin bad++; $display("FAIL rn_timeout got left=%0d want left=0", exp_chg_q.size()); exp_chg_q.delete(); end
        total++; if (chg_valid !== 1'b0 || state_dbg !== 2'd0)
            begin bad++; $display("FAIL rn_end got cv=%b st=%0d want cv=0 st=0", chg_valid, state_dbg); end
        chg_ready = 1'b0;
    endtask

    task automatic test_cancel_coin();
        logic [2:0] e;
        pulse_coin(3'd2);
        pulse_coin(3'd1);
        pulse_coin(3'd0);
        total++; if (disp_cents !== 10'd40) begin bad++; $display("FAIL cc_credit got=%0d want=40", disp_cents); end
        exp_chg_q.push_back(3'd2);
        exp_chg_q.push_back(3'd1);
        exp_chg_q.push_back(3'd0);
        cancel = 1'b1; coin_valid = 1'b1; coin_type = 3'd1; sel_valid = 1'b1; sel_idx = 4'd0;
        @(negedge clk);
        cancel = 1'b0; coin_valid = 1'b0; sel_valid = 1'b0;
        total++; if (coin_rej !== 1'b1 || sel_nak !== 1'b0 || vend_valid !== 1'b0 || state_dbg !== 2'd3 || disp_cents !== 10'd40)
            begin bad++; $display("FAIL cc_same_cycle got rej=%b nak=%b v=%b st=%0d disp=%0d want rej=1 nak=0 v=0 st=3 disp=40", coin_rej, sel_nak, vend_valid, state_dbg, disp_cents); end
        for (int i = 0; i < 3; i++) begin
            total++; if (chg_valid !== 1'b1 || chg_type !== 3'd2)
                begin bad++; $display("FAIL cc_stall got cv=%b type=%0d want cv=1 type=2", chg_valid, chg_type); end
            @(negedge clk);
        end
        chg_ready = 1'b1;
        for (int i = 0; i < 10 && exp_chg_q.size() != 0; i++) begin
            if (chg_valid && chg_ready) begin
                e = exp_chg_q.pop_front();
                total++; if (chg_type !== e) begin bad++; $display("FAIL cc_coin got=%0d want=%0d", chg_type, e); end
            end
            @(negedge clk);
        end
        total++; if (exp_chg_q.size() != 0) begin bad++; $display("FAIL cc_timeout got left=%0d want left=0", exp_chg_q.size()); exp_chg_q.delete(); end
        total++; if (chg_valid !== 1'b0 || state_dbg !== 2'd0)
            begin bad++; $display("FAIL cc_end got cv=%b st=%0d want cv=0 st=0", chg_valid, state_dbg); end
        chg_ready = 1'b0;
    endtask

    task automatic test_price_check();
        total++; if (disp_cents !== 10'd0) begin bad++; $display("FAIL pc_cleared got=%0d want=0", disp_cents); end
        pulse_sel(4'd0);
        total++; if (disp_cents !== 10'd125 || sel_nak !== 1'b0 || vend_valid !== 1'b0 || state_dbg !== 2'd0)
            begin bad++; $display("FAIL pc_slot0 got disp=%0d nak=%b v=%b st=%0d want disp=125 nak=0 v=0 st=0", disp_cents, sel_nak, vend_valid, state_dbg); end
        pulse_sel(4'd2);
        total++; if (disp_cents !== 10'd0) begin bad++; $display("FAIL pc_slot2 got=%0d want=0", disp_cents); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] e;
        pulse_coin(3'd4);
        pulse_cancel();
        total++; if (chg_valid !== 1'b1) begin bad++; $display("FAIL rm_in_change got=%b want=1", chg_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (chg_valid !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL rm_async got cv=%b busy=%b want cv=0 busy=0", chg_valid, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (state_dbg !== 2'd0 || disp_cents !== 10'd0 || r_led !== 9'h1FF || g_led !== 9'h000)
            begin bad++; $display("FAIL rm_after got st=%0d disp=%0d r=%h g=%h want st=0 disp=0 r=1ff g=000", state_dbg, disp_cents, r_led, g_led); end
        pulse_coin(3'd0);
        total++; if (disp_cents !== 10'd5 || state_dbg !== 2'd1)
            begin bad++; $display("FAIL rm_credit_zero got disp=%0d st=%0d want disp=5 st=1", disp_cents, state_dbg); end
        chg_ready = 1'b1;
        exp_chg_q.push_back(3'd0);
        pulse_cancel();
        for (int i = 0; i < 5 && exp_chg_q.size() != 0; i++) begin
            if (chg_valid && chg_ready) begin
                e = exp_chg_q.pop_front();
                total++; if (chg_type !== e) begin bad++; $display("FAIL rm_coin got=%0d want=%0d", chg_type, e); end
            end
            @(negedge clk);
        end
        total++; if (exp_chg_q.size() != 0) begin bad++; $display("FAIL rm_timeout got left=%0d want left=0", exp_chg_q.size()); exp_chg_q.delete(); end
        chg_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        price_wr = 1'b0; price_idx = '0; price_data = '0;
        coin_valid = 1'b0; coin_type = '0;
        sel_valid = 1'b0; sel_idx = '0;
        cancel = 1'b0; chg_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_price_write();
        test_vend_exact();
        test_vend_change();
        test_reject_nak();
        test_cancel_coin();
        test_price_check();
        test_reset_mid();
        total++; if (exp_vend_q.size() != 0) begin bad++; $display("FAIL vend_queue got left=%0d want left=0", exp_vend_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
